// File: rtl/rhythm_game_ctrl.sv
// rtl/rhythm_game_ctrl.sv - two-player note-lane game sequencer with hit judging and scores
module rhythm_game_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int HIT_Y       = 400,
  parameter int HIT_WIN     = 16,
  parameter int ROUND_NOTES = 16,
  parameter int WIN_SCORE   = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [2:0] i_btn,
  output logic [1:0] o_state,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [9:0] o_note_y,
  output logic [2:0] o_note_lanes,
  output logic [2:0] o_note_idx,
  output logic       o_hit_pulse,
  output logic       o_miss_pulse
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [9:0] LAST_Y     = 10'(SCREEN_H - 1);
  localparam logic [9:0] WIN_LO     = 10'(HIT_Y - HIT_WIN);
  localparam logic [9:0] WIN_HI     = 10'(HIT_Y + HIT_WIN);
  localparam logic [4:0] LAST_ROUND = 5'(ROUND_NOTES - 1);
  localparam logic [3:0] MAX_SCORE  = 4'(WIN_SCORE);

  state_t     r_state,    w_state;
  logic [3:0] r_p1,       w_p1;
  logic [3:0] r_p2,       w_p2;
  logic [9:0] r_note_y,   w_note_y;
  logic [2:0] r_note_idx, w_note_idx;
  logic [4:0] r_round,    w_round;
  logic       r_consumed, w_consumed;
  logic [2:0] r_btn_q;
  logic       r_hit,      w_hit;
  logic       r_miss,     w_miss;

  logic [2:0] w_pattern;
  logic       w_press;
  logic       w_in_win;

  // Fixed pattern table; pattern 000 is a rest
  always_comb begin
    w_pattern = 3'b000;
    case (r_note_idx)
      3'd0:    w_pattern = 3'b000;
      3'd1:    w_pattern = 3'b001;
      3'd2:    w_pattern = 3'b010;
      3'd3:    w_pattern = 3'b100;
      3'd4:    w_pattern = 3'b001;
      3'd5:    w_pattern = 3'b010;
      3'd6:    w_pattern = 3'b100;
      default: w_pattern = 3'b111;
    endcase
  end

  assign w_press  = |(i_btn & ~r_btn_q);
  assign w_in_win = (r_note_y >= WIN_LO) && (r_note_y <= WIN_HI);

  // Next-state: judge the press against the pre-tick position, then apply the scroll/wrap
  always_comb begin
    w_state    = r_state;
    w_p1       = r_p1;
    w_p2       = r_p2;
    w_note_y   = r_note_y;
    w_note_idx = r_note_idx;
    w_round    = r_round;
    w_consumed = r_consumed;
    w_hit      = 1'b0;
    w_miss     = 1'b0;
    case (r_state)
      QI: begin
        if (i_start) begin
          w_state    = QGAME_1;
          w_p1       = 4'd0;
          w_p2       = 4'd0;
          w_note_y   = 10'd0;
          w_note_idx = 3'd0;
          w_round    = 5'd0;
          w_consumed = 1'b0;
        end
      end
      QGAME_1, QGAME_2: begin
        if (w_press && (w_pattern != 3'b000) && !r_consumed) begin
          w_consumed = 1'b1;
          if (w_in_win && (i_btn == w_pattern)) begin
            w_hit = 1'b1;
            if (r_state == QGAME_1) begin
              if (r_p1 < MAX_SCORE) w_p1 = r_p1 + 4'd1;
            end else begin
              if (r_p2 < MAX_SCORE) w_p2 = r_p2 + 4'd1;
            end
          end
        end
        if (i_tick) begin
          if (r_note_y == LAST_Y) begin
            w_note_y   = 10'd0;
            w_note_idx = r_note_idx + 3'd1;
            w_consumed = 1'b0;
            w_round    = r_round + 5'd1;
            w_miss     = (w_pattern != 3'b000) && !r_consumed;
            if (r_round == LAST_ROUND) begin
              w_state    = (r_state == QGAME_1) ? QGAME_2 : QDONE;
              w_note_idx = 3'd0;
              w_round    = 5'd0;
            end
          end else begin
            w_note_y = r_note_y + 10'd1;
          end
        end
      end
      default: begin
        if (!i_start) w_state = QI;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= QI;
      r_p1       <= 4'd0;
      r_p2       <= 4'd0;
      r_note_y   <= 10'd0;
      r_note_idx <= 3'd0;
      r_round    <= 5'd0;
      r_consumed <= 1'b0;
      r_btn_q    <= 3'b000;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_p1       <= w_p1;
      r_p2       <= w_p2;
      r_note_y   <= w_note_y;
      r_note_idx <= w_note_idx;
      r_round    <= w_round;
      r_consumed <= w_consumed;
      r_btn_q    <= i_btn;
      r_hit      <= w_hit;
      r_miss     <= w_miss;
    end
  end

  assign o_state      = r_state;
  assign o_p1_score   = r_p1;
  assign o_p2_score   = r_p2;
  assign o_note_y     = r_note_y;
  assign o_note_idx   = r_note_idx;
  assign o_note_lanes = r_consumed ? 3'b000 : w_pattern;
  assign o_hit_pulse  = r_hit;
  assign o_miss_pulse = r_miss;

endmodule

// File: doc/rhythm_game_ctrl.md
Name: rhythm_game_ctrl

Overview:
- Game sequencer for the VGA note-lane display and the LED score/state indicators.
- Runs the QI / QGAME_1 / QGAME_2 / QDONE state machine for two players.
- Scrolls one note at a time down the screen, taking patterns from an internal 8-entry pattern table.
- Judges button presses against a hit window and keeps the per-player scores the display and LED logic consume.

Parameters:
- SCREEN_H, 480: visible lines; note_y runs 0..SCREEN_H-1.
- HIT_Y, 400: centre line of the hit window.
- HIT_WIN, 16: half-width of the hit window in lines. Hit is legal when HIT_Y-HIT_WIN <= note_y <= HIT_Y+HIT_WIN. Requires HIT_Y+HIT_WIN < SCREEN_H-1.
- ROUND_NOTES, 16: notes per player round. Pattern index wraps modulo 8.
- WIN_SCORE, 10: score saturation value (4'b1010).

Ports:
- clk  in  1  system clock, e.g. DIV_CLK[1]
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle scroll enable, e.g. a DIV_CLK[21] rising-edge pulse
- start  in  1  level from Sw1
- btn  in  3  lane buttons {r,g,b}, already debounced
- state  out  2  00=QI, 01=QGAME_1, 10=QGAME_2, 11=QDONE
- p1_score  out  4  player 1 score
- p2_score  out  4  player 2 score
- note_y  out  10  current note vertical position
- note_lanes  out  3  lanes drawn for the current note; 0 once consumed
- note_idx  out  3  pattern table index
- hit_pulse  out  1  one-cycle pulse on a scored hit
- miss_pulse  out  1  one-cycle pulse when an unscored non-rest note leaves the screen

Behaviour:
- Clocking: all state updates on posedge clk. All outputs are registered and reflect an event one cycle after the event's inputs are sampled.
- Reset (sync): state=QI; scores=0; note_y=0; note_idx=0; round count=0; consumed=0; btn_q=0; pulses=0.
- Pattern table (fixed), index 0..7: 000, 001, 010, 100, 001, 010, 100, 111. Pattern 000 is a rest.
- note_lanes = consumed ? 0 : table[note_idx].
- Press detection: btn_q <= btn every cycle. A press occurs when |(btn & ~btn_q) is 1. The press value is btn in that cycle.
- FSM transitions:
  - QI: start=1 -> QGAME_1. On entry, clear both scores, note_y, note_idx, round count and consumed.
  - QGAME_1: after ROUND_NOTES notes have wrapped -> QGAME_2. On entry, clear note_y, note_idx, round count and consumed; scores are kept.
  - QGAME_2: after ROUND_NOTES notes have wrapped -> QDONE.
  - QDONE: hold scores and state; start=0 -> QI.
- start is ignored in the game states. Deasserting start mid-round does not abort the round.
- Scroll (game states only): on tick, note_y <= note_y+1.
- Wrap (tick with note_y==SCREEN_H-1):
  - note_y <= 0; note_idx <= note_idx+1 (mod 8); consumed <= 0; round count +1.
  - miss_pulse=1 if the outgoing pattern was nonzero and not consumed.
  - When round count reaches ROUND_NOTES, the state transition happens in this same update.
- Judging a press while in a game state:
  - Note is a rest, or already consumed: press ignored.
  - note_y inside the window and press value == pattern: active player's score +1 (saturates at WIN_SCORE); consumed=1; hit_pulse=1.
  - Any other press on a non-rest, unconsumed note: consumed=1, no score, no pulse. One attempt per note.
- Press and tick in the same cycle: the press is judged against the pre-tick note_y; then the tick applies.
- A press in the wrap cycle is always outside the window (follows from HIT_Y+HIT_WIN < SCREEN_H-1).
- QI and QDONE: tick and btn are ignored; note_y and note_idx hold; pulses stay 0.
- Reset asserted mid-round overrides everything and returns to the reset values in the next cycle.

Test Plan:
- Start and scroll: reset, start=1 -> state=01 the next cycle. 5 ticks -> note_y=5, note_idx=0, note_lanes=000.
- Correct hit: advance to note_idx=1, note_y=400, press btn=001 -> one-cycle hit_pulse, p1_score=1, note_lanes=000. A second press on the same note -> no change.
- Out-of-window and wrong-lane: note_idx=2 at note_y=380, press 010 -> consumed, no score; at the wrap, miss_pulse=0. note_idx=3 at note_y=400, press 001 -> no score.
- Miss: let note_idx=4 (001) scroll to note_y=479 with no press, then tick -> miss_pulse=1, note_y=0, note_idx=5.
- Round sequencing and saturation:
  - 16 wraps -> state=10 with p1_score kept; another 16 -> state=11.
  - start=0 -> state=00; start=1 -> both scores cleared.
  - Force 12 correct hits -> score stays 10.
- Simultaneous and reset: press 111 on note_idx=7 at note_y=416 in the same cycle as a tick -> hit counted and note_y=417. Assert reset mid-round -> all outputs at reset values the next cycle.
